// File: rtl/sloth_pkg.sv
// Shared constants for the direction-bus receiver: channel geometry, piece and
// mode codes, channel indices and the receiver FSM encoding.
package sloth_pkg;

  localparam int NCH = 16;
  localparam int CHW = 5;

  // Piece codes; numeric order is also value order (lower = less valuable)
  localparam logic [2:0] PC_EMPTY  = 3'd0;
  localparam logic [2:0] PC_PAWN   = 3'd1;
  localparam logic [2:0] PC_KNIGHT = 3'd2;
  localparam logic [2:0] PC_BISHOP = 3'd3;
  localparam logic [2:0] PC_ROOK   = 3'd4;
  localparam logic [2:0] PC_QUEEN  = 3'd5;
  localparam logic [2:0] PC_KING   = 3'd6;

  localparam logic [1:0] MODE_INIT    = 2'b00;
  localparam logic [1:0] MODE_QUIET   = 2'b01;
  localparam logic [1:0] MODE_CAPTURE = 2'b10;
  localparam logic [1:0] MODE_PROMOTE = 2'b11;

  // Channel indices: direction points from the target square to the source
  localparam logic [3:0] CH_U   = 4'd0;
  localparam logic [3:0] CH_D   = 4'd1;
  localparam logic [3:0] CH_L   = 4'd2;
  localparam logic [3:0] CH_R   = 4'd3;
  localparam logic [3:0] CH_UL  = 4'd4;
  localparam logic [3:0] CH_UR  = 4'd5;
  localparam logic [3:0] CH_DL  = 4'd6;
  localparam logic [3:0] CH_DR  = 4'd7;
  localparam logic [3:0] CH_UUL = 4'd8;
  localparam logic [3:0] CH_UUR = 4'd9;
  localparam logic [3:0] CH_LLU = 4'd10;
  localparam logic [3:0] CH_RRU = 4'd11;
  localparam logic [3:0] CH_DDL = 4'd12;
  localparam logic [3:0] CH_DDR = 4'd13;
  localparam logic [3:0] CH_LLD = 4'd14;
  localparam logic [3:0] CH_RRD = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/direction_receiver_chan_filter.sv
// Combinational accept decision for one direction channel: hit bit, colour
// match, piece geometry for the channel and the pawn/non-pawn rules of the mode.
module chan_filter
  import sloth_pkg::*;
(
  input  logic [CHW-1:0] chan_i,
  input  logic [3:0]     idx_i,
  input  logic [1:0]     mode_i,
  input  logic           color_i,
  output logic           accept_o
);

  logic       hit;
  logic       col;
  logic [2:0] pc;
  logic       is_orth;
  logic       is_diag;
  logic       is_jump;
  logic       is_push;
  logic       is_cap;
  logic       slide_ok;
  logic       pawn_ok;
  logic       other_ok;

  assign hit = chan_i[4];
  assign col = chan_i[3];
  assign pc  = chan_i[2:0];

  assign is_orth = (idx_i[3:2] == 2'b00);
  assign is_diag = (idx_i[3:2] == 2'b01);
  assign is_jump = idx_i[3];

  // White pawns arrive from below the target, black pawns from above
  assign is_push = color_i ? (idx_i == CH_U) : (idx_i == CH_D);
  assign is_cap  = color_i ? ((idx_i == CH_UL) || (idx_i == CH_UR))
                           : ((idx_i == CH_DL) || (idx_i == CH_DR));

  // Geometry check for non-pawn pieces
  always_comb begin
    slide_ok = 1'b0;
    case (pc)
      PC_KNIGHT: slide_ok = is_jump;
      PC_BISHOP: slide_ok = is_diag;
      PC_ROOK:   slide_ok = is_orth;
      PC_QUEEN:  slide_ok = is_orth | is_diag;
      PC_KING:   slide_ok = is_orth | is_diag;
      default:   slide_ok = 1'b0;
    endcase
  end

  assign pawn_ok  = (pc == PC_PAWN) &&
                    ((is_push && ((mode_i == MODE_QUIET)   || (mode_i == MODE_PROMOTE))) ||
                     (is_cap  && ((mode_i == MODE_CAPTURE) || (mode_i == MODE_PROMOTE))));
  assign other_ok = slide_ok && ((mode_i == MODE_QUIET) || (mode_i == MODE_CAPTURE));

  assign accept_o = hit && (col == color_i) && (pawn_ok || other_ok);

endmodule

// File: rtl/direction_receiver.sv
// Receiver end of the 16-channel direction bus. Latches one job, walks the
// channels one per cycle, emits a move record per accepted channel over
// valid/ready and tracks the count and the least-valuable accepted attacker.
//
// Handshake: mv_valid is raised only while the current channel is accepted and
// unmasked; once high it and all mv_* fields stay constant until the cycle in
// which mv_ready is also high, and the record is consumed on that clock edge.
module direction_receiver
  import sloth_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic                 engine_color,
  input  logic                 mask,
  input  logic [5:0]           pos_reg,
  input  logic [NCH*CHW-1:0]   dir_in,
  output logic                 mv_valid,
  input  logic                 mv_ready,
  output logic [5:0]           mv_to,
  output logic [3:0]           mv_dir,
  output logic [2:0]           mv_piece,
  output logic [1:0]           mv_mode,
  output logic                 busy,
  output logic                 done,
  output logic [4:0]           hit_count,
  output logic                 best_vld,
  output logic [3:0]           best_dir,
  output logic [2:0]           best_piece,
  output logic [1:0]           dbg_state
);

  state_e             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic [NCH*CHW-1:0] dir_q, dir_d;
  logic [5:0]         pos_q, pos_d;
  logic [1:0]         mode_q, mode_d;
  logic               color_q, color_d;
  logic               mask_q, mask_d;
  logic [4:0]         count_q, count_d;
  logic               best_vld_q, best_vld_d;
  logic [3:0]         best_dir_q, best_dir_d;
  logic [2:0]         best_piece_q, best_piece_d;

  logic [CHW-1:0]     chans [NCH];
  logic [CHW-1:0]     cur_chan;
  logic [2:0]         cur_piece;
  logic               accept;
  logic               take;
  logic               advance;

  // Split the latched bus into per-channel fields
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      chans[i] = dir_q[i*CHW +: CHW];
    end
  end

  assign cur_chan  = chans[idx_q];
  assign cur_piece = cur_chan[2:0];

  chan_filter u_filter (
    .chan_i   (cur_chan),
    .idx_i    (idx_q),
    .mode_i   (mode_q),
    .color_i  (color_q),
    .accept_o (accept)
  );

  // Next-state: job latch, channel walk, count and best-attacker tracking
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    dir_d        = dir_q;
    pos_d        = pos_q;
    mode_d       = mode_q;
    color_d      = color_q;
    mask_d       = mask_q;
    count_d      = count_q;
    best_vld_d   = best_vld_q;
    best_dir_d   = best_dir_q;
    best_piece_d = best_piece_q;
    take         = 1'b0;
    advance      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dir_d        = dir_in;
          pos_d        = pos_reg;
          mode_d       = mode;
          color_d      = engine_color;
          mask_d       = mask;
          idx_d        = 4'd0;
          count_d      = 5'd0;
          best_vld_d   = 1'b0;
          best_dir_d   = 4'd0;
          best_piece_d = 3'd0;
          // INIT accepts nothing, so skip the walk entirely
          state_d      = (mode == MODE_INIT) ? ST_DONE : ST_SCAN;
        end
      end
      ST_SCAN: begin
        // Rejected and masked channels never wait; a record waits for ready
        advance = !accept || mask_q || mv_ready;
        take    = accept && (mask_q || mv_ready);
        if (take) begin
          count_d = count_q + 5'd1;
          if (!best_vld_q || (cur_piece < best_piece_q)) begin
            best_vld_d   = 1'b1;
            best_dir_d   = idx_q;
            best_piece_d = cur_piece;
          end
        end
        if (advance) begin
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd15) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched-job registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= 4'd0;
      dir_q        <= '0;
      pos_q        <= 6'd0;
      mode_q       <= 2'd0;
      color_q      <= 1'b0;
      mask_q       <= 1'b0;
      count_q      <= 5'd0;
      best_vld_q   <= 1'b0;
      best_dir_q   <= 4'd0;
      best_piece_q <= 3'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      dir_q        <= dir_d;
      pos_q        <= pos_d;
      mode_q       <= mode_d;
      color_q      <= color_d;
      mask_q       <= mask_d;
      count_q      <= count_d;
      best_vld_q   <= best_vld_d;
      best_dir_q   <= best_dir_d;
      best_piece_q <= best_piece_d;
    end
  end

  assign mv_valid   = (state_q == ST_SCAN) && accept && !mask_q;
  assign mv_to      = pos_q;
  assign mv_dir     = idx_q;
  assign mv_piece   = cur_piece;
  assign mv_mode    = mode_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign hit_count  = count_q;
  assign best_vld   = best_vld_q;
  assign best_dir   = best_dir_q;
  assign best_piece = best_piece_q;
  assign dbg_state  = state_q;

endmodule
